// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, derived totals and sync window bounds.
// Used by the sync generator and by any pixel consumer that needs the same geometry.
package vga_timing_pkg;

    // Master clocks per pixel: 100 MHz master to 25 MHz pixel rate
    localparam int unsigned VGA_CLK_DIV = 4;

    // Horizontal timing, in pixels
    localparam int unsigned VGA_H_VISIBLE = 640;
    localparam int unsigned VGA_H_FP      = 16;
    localparam int unsigned VGA_H_SYNC    = 96;
    localparam int unsigned VGA_H_BP      = 48;
    localparam int unsigned VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int unsigned VGA_H_SYNC_START = VGA_H_VISIBLE + VGA_H_FP;
    localparam int unsigned VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC - 1;

    // Vertical timing, in lines
    localparam int unsigned VGA_V_VISIBLE = 480;
    localparam int unsigned VGA_V_FP      = 10;
    localparam int unsigned VGA_V_SYNC    = 2;
    localparam int unsigned VGA_V_BP      = 33;
    localparam int unsigned VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
    localparam int unsigned VGA_V_SYNC_START = VGA_V_VISIBLE + VGA_V_FP;
    localparam int unsigned VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC - 1;

    // Output widths
    localparam int unsigned POS_W       = 10;
    localparam int unsigned FRAME_CNT_W = 8;

    typedef logic [POS_W-1:0]       pos_t;
    typedef logic [FRAME_CNT_W-1:0] frame_cnt_t;

    // Registered per-pixel decode, kept together so it updates as one unit
    typedef struct packed {
        logic disp_ena;
        logic h_sync;
        logic v_sync;
    } sync_t;

    // Sync outputs idle high, display disabled
    localparam sync_t SYNC_IDLE = '{disp_ena: 1'b0, h_sync: 1'b1, v_sync: 1'b1};

    // True when lo <= v <= hi (inclusive window)
    function automatic logic in_window(pos_t v, int unsigned lo, int unsigned hi);
        return (32'(v) >= lo) && (32'(v) <= hi);
    endfunction

endpackage

// File: rtl/vga_pixel_tick.sv
// Clock-enable divider: counts 0..CLK_DIV-1 and strobes on the last count.
// With CLK_DIV = 1 the counter is pinned at 0 and the strobe stays high.
module vga_pixel_tick #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic advance
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Strobe on the terminal count and wrap the divider there
    always_comb begin
        advance = (cnt_q == CNT_LAST);
        cnt_d   = advance ? '0 : cnt_q + 1'b1;
    end

    // Divider state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster generator: pixel/line counters, sync and display-enable decode,
// frame-start pulse and frame counter. All outputs are registered and change
// on the same edge as the counters, so position and sync never skew.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV   = VGA_CLK_DIV,
    parameter int unsigned H_VISIBLE = VGA_H_VISIBLE,
    parameter int unsigned H_FP      = VGA_H_FP,
    parameter int unsigned H_SYNC    = VGA_H_SYNC,
    parameter int unsigned H_BP      = VGA_H_BP,
    parameter int unsigned V_VISIBLE = VGA_V_VISIBLE,
    parameter int unsigned V_FP      = VGA_V_FP,
    parameter int unsigned V_SYNC    = VGA_V_SYNC,
    parameter int unsigned V_BP      = VGA_V_BP
) (
    input  logic                   Master_Clock_In,
    input  logic                   Reset_N_In,
    output logic                   Pixel_Tick_Out,
    output logic [POS_W-1:0]       Pixel_X_Out,
    output logic [POS_W-1:0]       Pixel_Y_Out,
    output logic                   Disp_Ena_Out,
    output logic                   H_Sync_Out,
    output logic                   V_Sync_Out,
    output logic                   Frame_Start_Out,
    output logic [FRAME_CNT_W-1:0] Frame_Count_Out
);

    localparam int unsigned H_TOTAL      = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned H_SYNC_START = H_VISIBLE + H_FP;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int unsigned V_TOTAL      = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int unsigned V_SYNC_START = V_VISIBLE + V_FP;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    localparam pos_t H_LAST = pos_t'(H_TOTAL - 1);
    localparam pos_t V_LAST = pos_t'(V_TOTAL - 1);

    logic       advance;
    pos_t       x_q, x_d;
    pos_t       y_q, y_d;
    sync_t      sync_q, sync_d;
    logic       tick_q;
    logic       frame_start_q, frame_start_d;
    frame_cnt_t frame_cnt_q, frame_cnt_d;

    vga_pixel_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_tick (
        .clk     (Master_Clock_In),
        .rst_n   (Reset_N_In),
        .advance (advance)
    );

    // Next raster position: X wraps every line, Y steps only when X wraps
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (advance) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                y_d = (y_q == V_LAST) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    // Decode from the next position so the registered decode lines up with the new (X,Y)
    always_comb begin
        sync_d          = sync_q;
        frame_start_d   = 1'b0;
        frame_cnt_d     = frame_cnt_q;
        if (advance) begin
            sync_d.disp_ena = (32'(x_d) < H_VISIBLE) && (32'(y_d) < V_VISIBLE);
            sync_d.h_sync   = !in_window(x_d, H_SYNC_START, H_SYNC_END);
            sync_d.v_sync   = !in_window(y_d, V_SYNC_START, V_SYNC_END);
            frame_start_d   = (x_d == '0) && (y_d == '0);
            if (frame_start_d) begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    // Counter and output registers; reset parks the raster on the last pixel so
    // the first advance lands on (0,0) and opens a new frame
    always_ff @(posedge Master_Clock_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            x_q           <= H_LAST;
            y_q           <= V_LAST;
            sync_q        <= SYNC_IDLE;
            tick_q        <= 1'b0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            sync_q        <= sync_d;
            tick_q        <= advance;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    // Output drive
    always_comb begin
        Pixel_Tick_Out  = tick_q;
        Pixel_X_Out     = x_q;
        Pixel_Y_Out     = y_q;
        Disp_Ena_Out    = sync_q.disp_ena;
        H_Sync_Out      = sync_q.h_sync;
        V_Sync_Out      = sync_q.v_sync;
        Frame_Start_Out = frame_start_q;
        Frame_Count_Out = frame_cnt_q;
    end

endmodule
